// File: rtl/uart_lp_pkg.sv
// Shared definitions for the low-power UART transmitter:
// state codes, frame-length helper and parameter legality.
package uart_lp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    function automatic int unsigned frame_cycles(
        input int unsigned clk_div,
        input int unsigned data_bits,
        input int unsigned parity_en,
        input int unsigned stop_bits
    );
        return clk_div * (1 + data_bits + parity_en + stop_bits);
    endfunction

    function automatic bit params_ok(
        input int unsigned clk_div,
        input int unsigned data_bits,
        input int unsigned parity_en,
        input int unsigned parity_odd,
        input int unsigned stop_bits,
        input int unsigned fifo_depth
    );
        bit ok;
        ok = (clk_div >= 2);
        ok = ok && (data_bits >= 5) && (data_bits <= 9);
        ok = ok && (parity_en <= 1) && (parity_odd <= 1);
        ok = ok && ((stop_bits == 1) || (stop_bits == 2));
        ok = ok && (fifo_depth >= 2);
        ok = ok && ((fifo_depth & (fifo_depth - 1)) == 0);
        return ok;
    endfunction

endpackage

// File: rtl/uart_lp_fifo.sv
// Synchronous transmit FIFO with registered occupancy level.
// A push into a full FIFO is refused even when a pop happens alongside.
module uart_lp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset; the level and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_lp_tx_fifo.sv
// Low-power UART transmitter with configurable frame, transmit FIFO
// and clock-enable request with an idle hold-off.
module uart_lp_tx_fifo
    import uart_lp_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDLE_HOLD  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [2:0]                    state,
    output logic                          clk_enable,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV_MAX =
        ((CLK_DIV - 1) > IDLE_HOLD) ? (CLK_DIV - 1) : IDLE_HOLD;
    localparam int unsigned DW = $clog2(DIV_MAX + 1);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic        PAR_ODD = (PARITY_ODD != 0);

    if (!params_ok(CLK_DIV, DATA_BITS, PARITY_EN, PARITY_ODD,
                   STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
        $error("uart_lp_tx_fifo: illegal parameter set");
    end

    state_e               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 load;
    logic                 bit_end;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_lp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_valid),
        .data_i  (wr_data),
        .pop_i   (load),
        .data_o  (fifo_data),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bit_end = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q + DW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                load  = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    div_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    div_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    div_d = '0;
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_HOLD;
                        load    = !fifo_empty;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_HOLD: begin
                load = !fifo_empty;
                if (div_q == DW'(IDLE_HOLD)) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A pending byte always wins over HOLD/IDLE, giving gapless frames.
        if (load) begin
            state_d = ST_START;
            div_d   = '0;
            bit_d   = '0;
            shift_d = fifo_data;
            par_d   = (^fifo_data) ^ PAR_ODD;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign state      = state_q;
    assign wr_ready   = !fifo_full;
    assign busy       = (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});
    assign clk_enable = (state_q != ST_IDLE) || (fifo_level != '0) || wr_valid;

endmodule

// File: tb/tb_uart_lp_tx_fifo.sv
// Self-checking bench: byte tables, parity/stop variants, corner
// sequences and random traffic against a frame-timeline model.
module tb_uart_lp_tx_fifo;

    localparam int CD    = 16;
    localparam int F     = 160;
    localparam int IH    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wv0 = 1'b0;
    logic       wv1 = 1'b0;
    logic [7:0] wd  = 8'h00;

    logic       rdy0, tx0, busy0, ce0;
    logic [2:0] st0, lvl0;
    logic       rdy1, tx1, busy1, ce1;
    logic [2:0] st1, lvl1;
    logic       rdy2, tx2, busy2, ce2;
    logic [2:0] st2, lvl2;

    always #5 clk = ~clk;

    uart_lp_tx_fifo u0 (
        .clk(clk), .rst(rst), .wr_valid(wv0), .wr_data(wd),
        .wr_ready(rdy0), .tx(tx0), .busy(busy0), .state(st0),
        .clk_enable(ce0), .fifo_level(lvl0)
    );

    uart_lp_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .wr_valid(wv1), .wr_data(wd),
        .wr_ready(rdy1), .tx(tx1), .busy(busy1), .state(st1),
        .clk_enable(ce1), .fifo_level(lvl1)
    );

    uart_lp_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .wr_valid(wv1), .wr_data(wd),
        .wr_ready(rdy2), .tx(tx2), .busy(busy2), .state(st2),
        .clk_enable(ce2), .fifo_level(lvl2)
    );

    typedef struct {
        logic [7:0] d;
        int         e;
    } ent_t;

    typedef struct {
        logic [7:0] d;
        logic [9:0] pat;
    } vec_t;

    ent_t       q[$];
    int         ecnt     = 0;
    int         last_pop = -100000;
    logic [7:0] cur      = 8'h00;
    int         n_chk    = 0;
    int         n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %h expected %h",
                     nm, ecnt, act, exp);
        end
    endtask

    // One clock edge with the given u0 inputs; the model predicts every
    // u0 output from the frame timeline (pop time + frame length).
    task automatic tick(input logic v, input logic [7:0] d, input logic r);
        int         szb, o, idx;
        logic       acc, pop, txe, bsy, cee;
        logic [2:0] ste;
        ent_t       en;
        wv0 = v;
        wd  = d;
        rst = r;
        @(posedge clk);
        ecnt++;
        szb = q.size();
        if (r) begin
            q.delete();
            last_pop = -100000;
        end else begin
            acc = v && (szb != DEPTH);
            pop = (szb > 0) && (q[0].e < ecnt) && ((ecnt - last_pop) >= F);
            if (pop) begin
                cur = q[0].d;
                void'(q.pop_front());
                last_pop = ecnt;
            end
            if (acc) begin
                en.d = d;
                en.e = ecnt;
                q.push_back(en);
            end
        end
        #1;
        o   = ecnt - last_pop;
        bsy = (o < F);
        if (o < F) begin
            idx = o / CD;
            ste = (idx == 0) ? 3'd1 : (idx <= 8) ? 3'd2 : 3'd4;
        end else if (o < F + IH + 1) begin
            ste = 3'd5;
        end else begin
            ste = 3'd0;
        end
        txe = 1'b1;
        if ((o - 1) >= 0 && (o - 1) < F) begin
            idx = (o - 1) / CD;
            if (idx == 0) txe = 1'b0;
            else if (idx <= 8) txe = cur[idx-1];
        end
        cee = (ste != 3'd0) || (q.size() != 0) || v;
        chk("cyc", {22'd0, tx0, busy0, st0, ce0, rdy0, lvl0},
            {22'd0, txe, bsy, ste, cee, (q.size() != DEPTH), 3'(q.size())});
    endtask

    initial begin
        vec_t tbl[5];
        int   t0, nss, maxl, nrdy0, p;
        logic [11:0] pe, po;
        logic [2:0]  prev;

        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h3C, 10'b1001111000};
        tbl[2] = '{8'h00, 10'b1000000000};
        tbl[3] = '{8'hFF, 10'b1111111110};
        tbl[4] = '{8'h81, 10'b1100000010};
        pe = 12'b111000001110;
        po = 12'b110000001110;

        repeat (3) tick(1'b0, 8'h00, 1'b1);
        chk("rst_tx", tx0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_state", st0, 0);
        chk("rst_ce", ce0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_level", lvl0, 0);
        chk("rst_u1_tx", tx1, 1);
        wv0 = 1'b1;
        #1;
        chk("rst_ce_follows_wv", ce0, 1);

        for (int i = 0; i < 5; i++) begin
            tick(1'b1, tbl[i].d, 1'b0);
            t0 = ecnt;
            for (int r = 1; r <= 170; r++) begin
                tick(1'b0, 8'h00, 1'b0);
                if (r == 1) chk("lat_tx_hi", tx0, 1);
                if (r == 2) chk("lat_tx_lo", tx0, 0);
                if (r >= 10 && (r - 10) % 16 == 0 && (r - 10) / 16 < 10) begin
                    chk("tbl_bit", tx0, tbl[i].pat[(r-10)/16]);
                    chk("tbl_busy", busy0, 1);
                end
                if (r == 161) chk("end_busy", busy0, 0);
                if (r == 165) chk("ce_hold", ce0, 1);
                if (r == 166) chk("ce_drop", ce0, 0);
            end
        end

        wv1 = 1'b1;
        tick(1'b0, 8'h07, 1'b0);
        wv1 = 1'b0;
        for (int r = 1; r <= 210; r++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (r >= 10 && (r - 10) % 16 == 0 && (r - 10) / 16 < 12) begin
                chk("par_even", tx1, pe[(r-10)/16]);
                chk("par_odd", tx2, po[(r-10)/16]);
            end
            if (r >= 162 && r < 194) chk("stop2_high", {tx1, tx2}, 2'b11);
            if (r == 192) chk("par_busy", busy1, 1);
            if (r == 193) chk("par_busy_end", busy1, 0);
        end

        for (int i = 0; i < 5; i++) begin
            chk("b2b_ready", rdy0, 1);
            tick(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        end
        nss  = 0;
        prev = st0;
        for (int r = 0; r < 5 * F + 20; r++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (prev == 3'd4 && st0 == 3'd1) nss++;
            prev = st0;
        end
        chk("b2b_stop_start", nss, 4);

        maxl  = 0;
        nrdy0 = 0;
        for (int r = 0; r < 400; r++) begin
            tick(1'b1, 8'($urandom), 1'b0);
            if (int'(lvl0) > maxl) maxl = int'(lvl0);
            if (!rdy0) nrdy0++;
        end
        chk("full_max_level", maxl, 4);
        chk("full_stalled", (nrdy0 > 0), 1);
        repeat (5 * F + 20) tick(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'hC0 + i), 1'b0);
        repeat (37) tick(1'b0, 8'h00, 1'b0);
        chk("pre_rst_state", st0, 2);
        chk("pre_rst_level", lvl0, 3);
        tick(1'b0, 8'h00, 1'b1);
        chk("mid_rst_tx", tx0, 1);
        chk("mid_rst_state", st0, 0);
        chk("mid_rst_level", lvl0, 0);
        chk("mid_rst_busy", busy0, 0);
        repeat (20) tick(1'b0, 8'h00, 1'b0);

        tick(1'b1, 8'h5A, 1'b0);
        repeat (163) tick(1'b0, 8'h00, 1'b0);
        chk("hold_state", st0, 5);
        tick(1'b1, 8'hE7, 1'b0);
        chk("hold_wr_state", st0, 5);
        chk("hold_wr_ce", ce0, 1);
        tick(1'b0, 8'h00, 1'b0);
        chk("hold_to_start", st0, 1);
        chk("hold_ce", ce0, 1);
        tick(1'b0, 8'h00, 1'b0);
        chk("hold_tx_start", tx0, 0);
        repeat (200) tick(1'b0, 8'h00, 1'b0);

        p = 0;
        for (int r = 0; r < 3000; r++) begin
            if (r % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       p = 0;
                    1:       p = 3;
                    2:       p = 30;
                    default: p = 90;
                endcase
            end
            tick($urandom_range(0, 99) < p, 8'($urandom),
                 $urandom_range(0, 999) == 0);
        end
        repeat (5 * F + 20) tick(1'b0, 8'h00, 1'b0);
        chk("final_idle", st0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
